// File: rtl/grid_lookup_buffer.sv
// Playfield occupancy grid with a registered display-side read port, a small
// write FIFO and a line-clear shifter. Updates are applied only between frames.
module grid_lookup_buffer #(
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [7:0] x_coord,
  input  logic [7:0] y_coord,
  output logic       coord_value,
  input  logic       draw_finish,
  input  logic       display_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic       wr_bit,
  input  logic       clr_valid,
  output logic       clr_ready,
  input  logic [4:0] clr_row,
  output logic       busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]      state;
  logic [COLS-1:0] grid [ROWS];
  logic [9:0]      fifo [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            clr_pending;
  logic [4:0]      clr_row_q, shift_row;
  logic            push, pop, fifo_empty, fifo_full;
  logic            shift_oor, shift_done;
  logic [9:0]      head;
  logic            rd_bit;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign wr_ready   = !fifo_full;
  assign push       = wr_valid && !fifo_full;
  assign pop        = (state == COMMIT) && !fifo_empty && !display_data;
  assign head       = fifo[rd_ptr];
  assign clr_ready  = !clr_pending;
  assign busy       = !fifo_empty || clr_pending || (state != IDLE);
  assign shift_oor  = ({1'b0, shift_row} >= 6'(ROWS));
  assign shift_done = shift_oor || (shift_row == '0);

  // Full-width coordinate compare gives 0 for any out-of-range query.
  always_comb begin
    rd_bit = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++)
        if (y_coord == 8'(r) && x_coord == 8'(c))
          rd_bit = grid[r][c];
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state       <= IDLE;
      clr_pending <= 1'b0;
      clr_row_q   <= '0;
      shift_row   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      coord_value <= 1'b0;
      for (int unsigned r = 0; r < ROWS; r++)
        grid[r] <= '0;
    end else begin
      coord_value <= rd_bit;

      if (push) begin
        fifo[wr_ptr] <= {wr_x, wr_y, wr_bit};
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;

      if (clr_valid && !clr_pending) begin
        clr_pending <= 1'b1;
        clr_row_q   <= clr_row;
      end

      case (state)
        IDLE: begin
          if (draw_finish) begin
            if (clr_pending) begin
              state     <= SHIFT;
              shift_row <= clr_row_q;
            end else if (!fifo_empty) begin
              state <= COMMIT;
            end
          end
        end
        SHIFT: begin
          if (!shift_oor) begin
            if (shift_row == '0)
              grid[0] <= '0;
            for (int unsigned r = 1; r < ROWS; r++)
              if (shift_row == 5'(r))
                grid[r] <= grid[r-1];
            shift_row <= shift_row - 1'b1;
          end
          if (shift_done) begin
            clr_pending <= 1'b0;
            state       <= fifo_empty ? IDLE : COMMIT;
          end
        end
        COMMIT: begin
          if (pop)
            for (int unsigned r = 0; r < ROWS; r++)
              for (int unsigned c = 0; c < COLS; c++)
                if (head[5:1] == 5'(r) && head[9:6] == 4'(c))
                  grid[r][c] <= head[0];
          if (display_data || fifo_empty || (count == CW'(1) && !push))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/grid_lookup_buffer.md
GRID_LOOKUP_BUFFER -- requirements
Module: grid_lookup_buffer

Interface
REQ-001 SHALL have parameter COLS, default 10: playfield width in cells.
REQ-002 SHALL have parameter ROWS, default 20: playfield height in cells; row 0 is the top row.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: number of pending cell writes held.
REQ-004 SHALL have vga_clk  in  1: the single clock; all logic is rising-edge.
REQ-005 SHALL have reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have x_coord  in  8: column of the cell queried by the display side.
REQ-007 SHALL have y_coord  in  8: row of the cell queried by the display side.
REQ-008 SHALL have coord_value  out  1: occupancy of the queried cell.
REQ-009 SHALL have draw_finish  in  1: one-cycle pulse at the end of the visible frame.
REQ-010 SHALL have display_data  in  1: high while the display is in the active pixel region.
REQ-011 SHALL have wr_valid  in  1, wr_ready  out  1, wr_x  in  4, wr_y  in  5, wr_bit  in  1: cell-write request channel.
REQ-012 SHALL have clr_valid  in  1, clr_ready  out  1, clr_row  in  5: line-clear request channel.
REQ-013 SHALL have busy  out  1: high while the FIFO is non-empty, a clear is pending, or state is not IDLE.

Function
REQ-014 SHALL hold a COLS x ROWS 1-bit grid in registers.
REQ-015 SHALL register coord_value 1 cycle after x_coord/y_coord, as grid[y][x] when x<COLS and y<ROWS, else 0.
REQ-016 SHALL serve reads in every state; reads during SHIFT/COMMIT return the grid contents as of that cycle.
REQ-017 SHALL drive wr_ready = FIFO not full; a write is accepted on wr_valid&&wr_ready and pushed as {wr_x,wr_y,wr_bit}.
REQ-018 SHALL NOT accept a push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-019 SHALL drive clr_ready = no clear pending; on clr_valid&&clr_ready it latches clr_row and sets clear-pending.
REQ-020 SHALL NOT modify the grid outside the SHIFT and COMMIT states (anti-tearing).
REQ-021 SHALL implement states IDLE, SHIFT, COMMIT.
REQ-022 IDLE: on draw_finish, go to SHIFT if a clear is pending; else to COMMIT if the FIFO is non-empty; else stay.
REQ-023 SHIFT: starting at r=clr_row and decrementing by one per cycle, grid[r]<=grid[r-1]; at r=0, grid[0]<=0 and the shift ends.
REQ-024 SHIFT with clr_row>=ROWS SHALL change no row and end after 1 cycle.
REQ-025 At SHIFT end, clear-pending SHALL be cleared, then go to COMMIT if the FIFO is non-empty, else IDLE.
REQ-026 SHIFT SHALL run to completion regardless of display_data, taking at most ROWS cycles.
REQ-027 COMMIT: pop one entry per cycle and write wr_bit to grid[wr_y][wr_x]; entries with wr_x>=COLS or wr_y>=ROWS are popped and dropped.
REQ-028 COMMIT SHALL go to IDLE when the FIFO becomes empty or when display_data=1, with no pop in that cycle if display_data=1; remaining entries wait for the next draw_finish.
REQ-029 SHALL ignore draw_finish outside IDLE.
REQ-030 SHALL apply FIFO entries in acceptance order; a later write to the same cell wins.

Reset
REQ-031 On reset the grid SHALL be all 0, FIFO empty, clear-pending 0, state IDLE, coord_value 0, wr_ready 1, clr_ready 1, busy 0.
REQ-032 Reset mid-SHIFT or mid-COMMIT SHALL abandon the operation; pending requests are lost.

Verification
REQ-033 Write (3,5,1) in IDLE, with no draw_finish -> coord_value at (3,5) stays 0; after draw_finish -> COMMIT -> (3,5) reads 1 with 1-cycle latency.
REQ-034 Push 4 writes -> wr_ready=0 and a 5th wr_valid is not accepted; after draw_finish, 4 pops occur over 4 cycles and wr_ready returns to 1.
REQ-035 Rows 18 and 19 full, row 17 has cell 0 set, clear row 19, then draw_finish -> after SHIFT row 19 is full, row 18 has only cell 0 set, row 0 is empty, clr_ready=1.
REQ-036 Raise display_data after 2 COMMIT pops with 4 queued -> 2 entries remain and busy=1; the next draw_finish applies them.
REQ-037 Query (10,0) and (0,20) -> coord_value=0; write (12,3,1) -> dropped and the grid is unchanged.
REQ-038 Assert reset during SHIFT -> the next cycle shows all outputs at their reset values and every grid cell reads 0.
